// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_engine
// Description : Copy/fill sequencer for a shared dual-port RAM. Reads source
//               words through port 0 (posedge RAM port) and writes them, or a
//               fill constant, through port 1 (negedge RAM port).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   words_done,
  output logic              wr_0,
  output logic              rd_0,
  output logic [ADDR_W-1:0] addr_0,
  inout  wire  [DATA_W-1:0] data_0,
  output logic              wr_1,
  output logic              rd_1,
  output logic [ADDR_W-1:0] addr_1,
  inout  wire  [DATA_W-1:0] data_1
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_CAP = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_mode;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_fill;
  logic [ADDR_W-1:0]   r_src_ptr;
  logic [ADDR_W-1:0]   r_dst_ptr;
  logic [DATA_W-1:0]   r_hold;
  logic [ADDR_W:0]     r_words_done;
  logic                r_aborted;

  logic                w_accept;
  logic [ADDR_W:0]     w_words_inc;
  logic                w_wr_last;
  logic [DATA_W-1:0]   w_wr_data;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_words_inc = r_words_done + {{ADDR_W{1'b0}}, 1'b1};
  assign w_wr_last   = (w_words_inc == r_len);
  assign w_wr_data   = r_mode ? r_fill : r_hold;

  // State register; an asynchronous reset drops any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-decoded RAM/handshake controls.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    aborted      = 1'b0;
    rd_0         = 1'b0;
    wr_1         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len == '0) begin
            w_next_state = S_DONE;
          end else if (mode) begin
            w_next_state = S_WR;
          end else begin
            w_next_state = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        rd_0         = 1'b1;
        w_next_state = abort ? S_DONE : S_RD_CAP;
      end
      S_RD_CAP: begin
        rd_0         = 1'b1;
        w_next_state = abort ? S_DONE : S_WR;
      end
      S_WR: begin
        wr_1 = 1'b1;
        // The write in this cycle always completes, even when aborting.
        if (w_wr_last || abort) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = r_mode ? S_WR : S_RD_REQ;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        aborted      = r_aborted;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Command latch, address pointers, read-hold register and progress count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= 1'b0;
      r_len        <= '0;
      r_fill       <= '0;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_hold       <= '0;
      r_words_done <= '0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode       <= mode;
        r_len        <= len;
        r_fill       <= fill_data;
        r_src_ptr    <= src_addr;
        r_dst_ptr    <= dst_addr;
        r_words_done <= '0;
        r_aborted    <= 1'b0;
      end
      case (r_state)
        S_RD_REQ: begin
          if (abort) r_aborted <= 1'b1;
        end
        S_RD_CAP: begin
          r_hold <= data_0;
          if (abort) r_aborted <= 1'b1;
        end
        S_WR: begin
          // Pointers wrap naturally at the top of the address space.
          r_words_done <= w_words_inc;
          r_src_ptr    <= r_src_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          r_dst_ptr    <= r_dst_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (abort) r_aborted <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign words_done = r_words_done;
  assign addr_0     = r_src_ptr;
  assign addr_1     = r_dst_ptr;
  assign wr_0       = 1'b0;
  assign rd_1       = 1'b0;
  // Port 0 is read-only for the engine; the RAM owns its data bus.
  assign data_0     = {DATA_W{1'bz}};
  assign data_1     = wr_1 ? w_wr_data : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_copy_engine
// Description : Bench for ram_copy_engine with a 16x8 dual-port RAM model and
//               an array-based reference of the expected memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] src_addr = '0;
  logic [3:0] dst_addr = '0;
  logic [4:0] len = '0;
  logic [7:0] fill_data = '0;
  logic       abort = 1'b0;
  logic       busy, done, aborted;
  logic [4:0] words_done;
  logic       wr_0, rd_0, wr_1, rd_1;
  logic [3:0] addr_0, addr_1;
  wire  [7:0] data_0;
  wire  [7:0] data_1;

  // RAM model state
  logic [7:0] ram [16];
  logic [7:0] ram_q = '0;
  logic       ram_oe = 1'b0;
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  // Reference memory image
  logic [7:0] exp_mem [16];

  int checks = 0;
  int errors = 0;

  ram_copy_engine #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_data(fill_data), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .wr_0(wr_0), .rd_0(rd_0), .addr_0(addr_0), .data_0(data_0),
    .wr_1(wr_1), .rd_1(rd_1), .addr_1(addr_1), .data_1(data_1)
  );

  always #5 clk = ~clk;

  // Port 0: address latched on posedge, data driven in the following cycle.
  always @(posedge clk) begin
    ram_oe <= rd_0;
    if (rd_0) ram_q <= ram[addr_0];
  end
  assign data_0 = ram_oe ? ram_q : 8'bz;

  // Port 1: write on negedge; backdoor preload port shares the same process.
  always @(negedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (wr_1) ram[addr_1] <= data_1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < 16; k++) begin
      checks++;
      assert (ram[k] === exp_mem[k]) else begin
        errors++;
        $error("FAIL %s mem[%0d] observed=%h expected=%h", tag, k, ram[k], exp_mem[k]);
      end
    end
  endtask

  task automatic preload();
    for (int k = 0; k < 16; k++) begin
      pre_we   = 1'b1;
      pre_addr = 4'(k);
      pre_data = 8'hA0 + 8'(k);
      exp_mem[k] = 8'hA0 + 8'(k);
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference: ascending word-by-word copy/fill of n words with wrap.
  task automatic model_apply(input logic m, input logic [3:0] s, input logic [3:0] d,
                             input logic [7:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      exp_mem[4'(d + 4'(i))] = m ? f : exp_mem[4'(s + 4'(i))];
    end
  endtask

  // Issue one command (called at #1 after a posedge) and check it end to end.
  // abort_cyc: cycle number after the start edge in which abort is held high
  // (0 = never). noise: keep strobing start with junk fields while busy.
  task automatic run_cmd(input string tag, input logic m, input logic [3:0] s,
                         input logic [3:0] d, input logic [4:0] n,
                         input logic [7:0] f, input int abort_cyc, input bit noise);
    int body, done_cyc, exp_rd, exp_wr, cyc, rdc, wrc, bad;
    bit ab;
    body = (n == 0) ? 0 : (m ? int'(n) : 3 * int'(n));
    if (abort_cyc >= 1 && abort_cyc <= body) begin
      ab = 1'b1;
      done_cyc = abort_cyc + 1;
    end else begin
      ab = 1'b0;
      done_cyc = body + 1;
    end
    // Copy schedule repeats read-request, read-capture, write; fill only writes.
    exp_rd = 0;
    exp_wr = 0;
    for (int c = 1; c < done_cyc; c++) begin
      if (m || ((c - 1) % 3 == 2)) exp_wr++;
      else exp_rd++;
    end
    model_apply(m, s, d, f, exp_wr);

    mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; rdc = 0; wrc = 0; bad = 0;
    while (done !== 1'b1 && cyc <= 100) begin
      if (rd_0 === 1'b1) rdc++;
      if (wr_1 === 1'b1) wrc++;
      if (busy !== 1'b1 || rd_1 !== 1'b0 || wr_0 !== 1'b0) bad++;
      abort = (cyc == abort_cyc);
      if (noise) begin
        start = 1'b1;
        mode = 1'($urandom);
        src_addr = 4'($urandom);
        dst_addr = 4'($urandom);
        len = 5'($urandom_range(0, 16));
        fill_data = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    check({tag, ".done_cycle"}, cyc, done_cyc);
    check({tag, ".aborted"}, aborted, ab);
    check({tag, ".busy_in_done"}, busy, 1);
    check({tag, ".words_done"}, words_done, exp_wr);
    check({tag, ".rd_cycles"}, rdc, exp_rd);
    check({tag, ".wr_cycles"}, wrc, exp_wr);
    check({tag, ".port_rules"}, bad, 0);
    @(posedge clk); #1;
    check({tag, ".done_after"}, done, 0);
    check({tag, ".aborted_after"}, aborted, 0);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".words_hold"}, words_done, exp_wr);
    check_mem(tag);
  endtask

  initial begin
    int seen;
    // Reset state
    @(posedge clk); #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.aborted", aborted, 0);
    check("rst.rd_0", rd_0, 0);
    check("rst.wr_1", wr_1, 0);
    check("rst.addr_0", addr_0, 0);
    check("rst.addr_1", addr_1, 0);
    check("rst.words_done", words_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload();
    run_cmd("copy_basic", 1'b0, 4'd2, 4'd10, 5'd4, 8'h00, 0, 1'b0);
    run_cmd("fill_wrap", 1'b1, 4'd0, 4'd14, 5'd4, 8'h5C, 0, 1'b0);
    run_cmd("copy_len0", 1'b0, 4'd3, 4'd7, 5'd0, 8'h00, 0, 1'b0);
    run_cmd("copy_noise", 1'b0, 4'd1, 4'd6, 5'd5, 8'h77, 0, 1'b1);
    run_cmd("copy_abort", 1'b0, 4'd0, 4'd4, 5'd8, 8'h00, 8, 1'b0);
    run_cmd("copy_full", 1'b0, 4'd0, 4'd0, 5'd16, 8'h00, 0, 1'b0);

    // Reset in the third WR cycle of a fill: two words already written.
    mode = 1'b1; dst_addr = 4'd9; len = 5'd8; fill_data = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstwr.pre_wr_1", wr_1, 1);
    rst_n = 1'b0;
    #1;
    check("rstwr.busy", busy, 0);
    check("rstwr.wr_1", wr_1, 0);
    check("rstwr.words_done", words_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("rstwr.no_done", seen, 0);
    exp_mem[9]  = 8'h3C;
    exp_mem[10] = 8'h3C;
    check_mem("rstwr");

    // Randomized commands against the reference image
    for (int t = 0; t < 25; t++) begin
      int ac;
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 49)) : 0;
      run_cmd("rand", 1'($urandom), 4'($urandom), 4'($urandom),
              5'($urandom_range(0, 16)), 8'($urandom), ac,
              ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
